// File: rtl/mseq_stream_gen.sv
// mseq_stream_gen: word-wide maximal-length LFSR stream generator with config handshake and start/stop control
module mseq_stream_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_WIDTH  = 8
) (
   input  logic                  MSEQ_clk,
   input  logic                  MSEQ_rst_n,
   input  logic                  MSEQ_cfg_valid,
   output logic                  MSEQ_cfg_ready,
   input  logic [DATA_WIDTH-1:0] MSEQ_seed,
   input  logic [DATA_WIDTH-1:0] MSEQ_init_value,
   input  logic                  MSEQ_start,
   input  logic                  MSEQ_stop,
   output logic [OUT_WIDTH-1:0]  MSEQ_out_data,
   output logic                  MSEQ_out_valid,
   input  logic                  MSEQ_out_ready,
   output logic                  MSEQ_busy,
   output logic                  MSEQ_lockup,
   output logic                  MSEQ_wrap
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] lfsr, seed_q, init_q, s;
   logic [OUT_WIDTH-1:0]  word;
   logic                  word_wrap, loaded, cfg_hs, cfg_bad, gen, out_free;

   // OUT_WIDTH serial steps unrolled; s ends as the state after the whole word
   always_comb begin
      s = lfsr;
      word = '0;
      word_wrap = 1'b0;
      for (int k = 0; k < OUT_WIDTH; k++) begin
         word[k] = s[0];
         s = {^(s & seed_q), s[DATA_WIDTH-1:1]};
         word_wrap = word_wrap | (s == init_q);
      end
   end

   always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n)
      if (!MSEQ_rst_n) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (MSEQ_start && loaded && !MSEQ_stop) state_nxt = RUN;
         RUN:     if (MSEQ_stop) state_nxt = DRAIN;
         DRAIN:   if (out_free) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      MSEQ_cfg_ready = state == IDLE;
      MSEQ_busy = state != IDLE;
      out_free = !MSEQ_out_valid || MSEQ_out_ready;
      cfg_hs = MSEQ_cfg_valid && MSEQ_cfg_ready;
      cfg_bad = ~|MSEQ_seed || ~|MSEQ_init_value;
      gen = state == RUN && !MSEQ_stop && out_free;
   end

   // a rejected load only flags lockup and disarms start; stored config and LFSR are kept
   always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n)
      if (!MSEQ_rst_n) begin
         seed_q <= '0;
         init_q <= '0;
         lfsr <= '0;
         loaded <= 1'b0;
         MSEQ_lockup <= 1'b0;
      end else begin
         if (cfg_hs) begin
            MSEQ_lockup <= cfg_bad;
            loaded <= !cfg_bad;
         end
         if (cfg_hs && !cfg_bad) begin
            seed_q <= MSEQ_seed;
            init_q <= MSEQ_init_value;
            lfsr <= MSEQ_init_value;
         end else if (gen) lfsr <= s;
      end

   always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n)
      if (!MSEQ_rst_n) begin
         MSEQ_out_data <= '0;
         MSEQ_out_valid <= 1'b0;
         MSEQ_wrap <= 1'b0;
      end else if (gen) begin
         MSEQ_out_data <= word;
         MSEQ_out_valid <= 1'b1;
         MSEQ_wrap <= word_wrap;
      end else if (MSEQ_out_ready) MSEQ_out_valid <= 1'b0;
endmodule
